// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter and its round-robin picker.
package fifo_arb_pkg;

   typedef enum logic {IDLE, LOCKED} arb_state_t;

   localparam int NREQ_DEF   = 4;
   localparam int DWIDTH_DEF = 8;
   localparam int CNTW_DEF   = 16;

   function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned nreq);
      return (ptr + 1 >= nreq) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Combinational round-robin search: first set bit of req starting at ptr, wrapping.
// Kept generic so the read side can reuse it.
module fifo_arb_rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          found,
   output logic [IW-1:0] idx
);

   always_comb begin
      found = |req;
      idx   = '0;
      // Walk from the farthest offset down so the nearest hit to ptr wins.
      for (int i = N - 1; i >= 0; i--) begin
         if (req[(int'(ptr) + i) % N]) idx = IW'((int'(ptr) + i) % N);
      end
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Packet-atomic round-robin arbiter for the single FIFO write port.
// Define FIFO_ARB_STATS_EN to add per-requester packet and stall counters.
//
// state  | meaning
// IDLE   | port free; pick next owner from rr_ptr, no write this cycle
// LOCKED | port owned by 'owner' until it writes a word flagged last
module fifo_write_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NREQ   = NREQ_DEF,
   parameter int DWIDTH = DWIDTH_DEF,
   parameter int CNTW   = CNTW_DEF
) (
   input  logic                     wclk,
   input  logic                     wrst_n,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ-1:0]          last,
   input  logic [NREQ*DWIDTH-1:0]   req_data,
   output logic [NREQ-1:0]          ack,
   input  logic                     full,
   output logic                     w_enable,
   output logic [DWIDTH-1:0]        wdata,
   output logic [$clog2(NREQ)-1:0]  grant_id,
   output logic                     busy
`ifdef FIFO_ARB_STATS_EN
   ,
   input  logic                     stat_clr,
   output logic [NREQ*CNTW-1:0]     stat_pkt_cnt,
   output logic [CNTW-1:0]          stat_stall_cnt
`endif
);

   localparam int IW = $clog2(NREQ);

   arb_state_t    state, state_nxt;
   logic [IW-1:0] owner, owner_nxt;
   logic [IW-1:0] rr_ptr, rr_ptr_nxt;
   logic          pick_found;
   logic [IW-1:0] pick_idx;
   logic          accept;

   fifo_arb_rr_pick #(.N(NREQ), .IW(IW)) u_pick (
      .req   (req),
      .ptr   (rr_ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         state  <= IDLE;
         owner  <= '0;
         rr_ptr <= '0;
      end else begin
         state  <= state_nxt;
         owner  <= owner_nxt;
         rr_ptr <= rr_ptr_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      owner_nxt  = owner;
      rr_ptr_nxt = rr_ptr;
      accept     = 1'b0;
      ack        = '0;
      w_enable   = 1'b0;
      wdata      = '0;
      unique case (state)
         IDLE: begin
            if (pick_found) begin
               owner_nxt = pick_idx;
               state_nxt = LOCKED;
            end
         end
         LOCKED: begin
            // full gates accept directly, so a write can never coincide with full
            accept     = req[owner] & ~full;
            w_enable   = accept;
            wdata      = req_data[owner*DWIDTH +: DWIDTH];
            ack[owner] = accept;
            if (accept && last[owner]) begin
               state_nxt  = IDLE;
               rr_ptr_nxt = IW'(rr_next(int'(owner), NREQ));
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy     = (state == LOCKED);
   assign grant_id = owner;

`ifdef FIFO_ARB_STATS_EN
   logic [CNTW-1:0] pkt_cnt [NREQ];
   logic [CNTW-1:0] stall_cnt;
   logic            stall;

   assign stall = (state == LOCKED) & req[owner] & full;

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         for (int i = 0; i < NREQ; i++) pkt_cnt[i] <= '0;
         stall_cnt <= '0;
      end else if (stat_clr) begin
         for (int i = 0; i < NREQ; i++) pkt_cnt[i] <= '0;
         stall_cnt <= '0;
      end else begin
         if (accept && last[owner] && (pkt_cnt[owner] != '1))
            pkt_cnt[owner] <= pkt_cnt[owner] + 1'b1;
         if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
      end
   end

   for (genvar g = 0; g < NREQ; g++) begin : g_stat
      assign stat_pkt_cnt[g*CNTW +: CNTW] = pkt_cnt[g];
   end
   assign stat_stall_cnt = stall_cnt;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed self-checking bench for fifo_write_arbiter (NREQ=4, DWIDTH=8, CNTW=4).
module tb_fifo_write_arbiter;

   logic        wclk = 1'b0;
   logic        wrst_n;
   logic [3:0]  req, last, ack;
   logic [7:0]  d [4];
   logic [31:0] req_data;
   logic        full, w_enable, busy;
   logic [7:0]  wdata;
   logic [1:0]  grant_id;
`ifdef FIFO_ARB_STATS_EN
   logic        stat_clr;
   logic [15:0] stat_pkt_cnt;
   logic [3:0]  stat_stall_cnt;
`endif

   int total = 0;
   int pass  = 0;

   assign req_data = {d[3], d[2], d[1], d[0]};

   always #5 wclk = ~wclk;

   fifo_write_arbiter #(.NREQ(4), .DWIDTH(8), .CNTW(4)) dut (
      .wclk     (wclk),
      .wrst_n   (wrst_n),
      .req      (req),
      .last     (last),
      .req_data (req_data),
      .ack      (ack),
      .full     (full),
      .w_enable (w_enable),
      .wdata    (wdata),
      .grant_id (grant_id),
      .busy     (busy)
`ifdef FIFO_ARB_STATS_EN
      ,
      .stat_clr       (stat_clr),
      .stat_pkt_cnt   (stat_pkt_cnt),
      .stat_stall_cnt (stat_stall_cnt)
`endif
   );

   task automatic tick();
      @(posedge wclk);
      #2;
   endtask

   task automatic do_reset();
      req = '0; last = '0; full = 1'b0;
      for (int i = 0; i < 4; i++) d[i] = '0;
`ifdef FIFO_ARB_STATS_EN
      stat_clr = 1'b0;
`endif
      wrst_n = 1'b0;
      tick();
      tick();
      wrst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      wrst_n = 1'b0;
      req = 4'b1111; last = 4'b1111; d[0] = 8'hFF;
      tick();
      #1;
      total++; if (busy !== 1'b0) $display("FAIL rst_busy got %0b exp 0", busy); else pass++;
      total++; if (grant_id !== 2'd0) $display("FAIL rst_grant_id got %0d exp 0", grant_id); else pass++;
      total++; if (w_enable !== 1'b0) $display("FAIL rst_w_enable got %0b exp 0", w_enable); else pass++;
      total++; if (ack !== 4'b0000) $display("FAIL rst_ack got %b exp 0000", ack); else pass++;
      total++; if (wdata !== 8'h00) $display("FAIL rst_wdata got %h exp 00", wdata); else pass++;
`ifdef FIFO_ARB_STATS_EN
      total++; if (stat_pkt_cnt !== 16'h0) $display("FAIL rst_pkt_cnt got %h exp 0000", stat_pkt_cnt); else pass++;
`endif
      req = '0; last = '0;
      wrst_n = 1'b1;
   endtask

   task automatic test_single_packet();
      logic [7:0] words [3];
      words[0] = 8'hA1; words[1] = 8'hA2; words[2] = 8'hA3;
      do_reset();
      req = 4'b0010; d[1] = words[0];
      #1;
      total++; if (w_enable !== 1'b0 || busy !== 1'b0) $display("FAIL pkt_idle_cycle got we=%0b busy=%0b exp 0 0", w_enable, busy); else pass++;
      tick();
      for (int w = 0; w < 3; w++) begin
         d[1] = words[w];
         last[1] = (w == 2);
         #1;
         total++; if (grant_id !== 2'd1 || busy !== 1'b1) $display("FAIL pkt_grant w%0d got id=%0d busy=%0b exp 1 1", w, grant_id, busy); else pass++;
         total++; if (w_enable !== 1'b1 || wdata !== words[w]) $display("FAIL pkt_write w%0d got we=%0b data=%h exp 1 %h", w, w_enable, wdata, words[w]); else pass++;
         total++; if (ack !== 4'b0010) $display("FAIL pkt_ack w%0d got %b exp 0010", w, ack); else pass++;
         tick();
      end
      req = '0; last = '0;
      #1;
      total++; if (busy !== 1'b0 || w_enable !== 1'b0) $display("FAIL pkt_bubble got busy=%0b we=%0b exp 0 0", busy, w_enable); else pass++;
   endtask

   task automatic test_fairness();
      do_reset();
      for (int i = 0; i < 4; i++) d[i] = 8'(i);
      req = 4'b1111; last = 4'b1111;
      for (int n = 0; n < 6; n++) begin
         #1;
         total++; if (w_enable !== 1'b0 || busy !== 1'b0) $display("FAIL rr_bubble n%0d got we=%0b busy=%0b exp 0 0", n, w_enable, busy); else pass++;
         tick();
         #1;
         total++; if (w_enable !== 1'b1 || wdata !== 8'(n % 4) || grant_id !== 2'(n % 4)) $display("FAIL rr_order n%0d got we=%0b data=%h id=%0d exp 1 %0d", n, w_enable, wdata, grant_id, n % 4); else pass++;
         total++; if (ack !== 4'(1 << (n % 4))) $display("FAIL rr_ack n%0d got %b exp %b", n, ack, 4'(1 << (n % 4))); else pass++;
         tick();
      end
      req = '0; last = '0;
   endtask

   task automatic test_stall();
      do_reset();
      req = 4'b0100; d[2] = 8'hB0;
      tick();
      #1;
      total++; if (w_enable !== 1'b1 || wdata !== 8'hB0) $display("FAIL stall_w0 got we=%0b data=%h exp 1 b0", w_enable, wdata); else pass++;
      tick();
      d[2] = 8'hB1; full = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         total++; if (w_enable !== 1'b0 || ack !== 4'b0000) $display("FAIL stall_gate c%0d got we=%0b ack=%b exp 0 0000", c, w_enable, ack); else pass++;
         total++; if (wdata !== 8'hB1 || busy !== 1'b1 || grant_id !== 2'd2) $display("FAIL stall_hold c%0d got data=%h busy=%0b id=%0d exp b1 1 2", c, wdata, busy, grant_id); else pass++;
         tick();
      end
      full = 1'b0;
      #1;
      total++; if (w_enable !== 1'b1 || wdata !== 8'hB1 || ack !== 4'b0100) $display("FAIL stall_resume got we=%0b data=%h ack=%b exp 1 b1 0100", w_enable, wdata, ack); else pass++;
      tick();
      d[2] = 8'hB2; last[2] = 1'b1;
      #1;
      total++; if (w_enable !== 1'b1 || wdata !== 8'hB2) $display("FAIL stall_w2 got we=%0b data=%h exp 1 b2", w_enable, wdata); else pass++;
      tick();
      req = '0; last = '0;
      #1;
      total++; if (busy !== 1'b0) $display("FAIL stall_end got busy=%0b exp 0", busy); else pass++;
`ifdef FIFO_ARB_STATS_EN
      total++; if (stat_stall_cnt !== 4'd5) $display("FAIL stall_cnt got %0d exp 5", stat_stall_cnt); else pass++;
      total++; if (stat_pkt_cnt[8 +: 4] !== 4'd1) $display("FAIL stall_pkt_cnt got %0d exp 1", stat_pkt_cnt[8 +: 4]); else pass++;
`endif
   endtask

   task automatic test_drop_req();
      do_reset();
      req = 4'b1001; d[0] = 8'hC0; d[3] = 8'hD0; last = 4'b0000;
      tick();
      #1;
      total++; if (grant_id !== 2'd0 || wdata !== 8'hC0 || ack !== 4'b0001) $display("FAIL drop_w0 got id=%0d data=%h ack=%b exp 0 c0 0001", grant_id, wdata, ack); else pass++;
      tick();
      req = 4'b1000; d[0] = 8'hC1;
      for (int c = 0; c < 3; c++) begin
         #1;
         total++; if (busy !== 1'b1 || grant_id !== 2'd0 || w_enable !== 1'b0 || ack !== 4'b0000) $display("FAIL drop_hold c%0d got busy=%0b id=%0d we=%0b ack=%b exp 1 0 0 0000", c, busy, grant_id, w_enable, ack); else pass++;
         tick();
      end
      req = 4'b1001; last = 4'b0001;
      #1;
      total++; if (w_enable !== 1'b1 || wdata !== 8'hC1 || ack !== 4'b0001) $display("FAIL drop_last got we=%0b data=%h ack=%b exp 1 c1 0001", w_enable, wdata, ack); else pass++;
      tick();
      req = 4'b1000; last = 4'b0000;
      #1;
      total++; if (busy !== 1'b0 || w_enable !== 1'b0) $display("FAIL drop_bubble got busy=%0b we=%0b exp 0 0", busy, w_enable); else pass++;
      tick();
      #1;
      total++; if (grant_id !== 2'd3 || wdata !== 8'hD0 || ack !== 4'b1000) $display("FAIL drop_next got id=%0d data=%h ack=%b exp 3 d0 1000", grant_id, wdata, ack); else pass++;
      req = '0;
   endtask

   task automatic test_reset_mid_packet();
      do_reset();
      // First packet from 0 moves rr_ptr to 1, so a later grant of 0 proves the reset cleared it.
      req = 4'b0001; last = 4'b0001; d[0] = 8'h10;
      tick();
      tick();
      req = 4'b1000; last = 4'b0000; d[3] = 8'hE0;
      tick();
      #1;
      total++; if (grant_id !== 2'd3 || w_enable !== 1'b1 || wdata !== 8'hE0) $display("FAIL rmid_w0 got id=%0d we=%0b data=%h exp 3 1 e0", grant_id, w_enable, wdata); else pass++;
      tick();
      wrst_n = 1'b0;
      #1;
      total++; if (busy !== 1'b0 || w_enable !== 1'b0 || ack !== 4'b0000) $display("FAIL rmid_abort got busy=%0b we=%0b ack=%b exp 0 0 0000", busy, w_enable, ack); else pass++;
      tick();
      req = 4'b1001; last = 4'b0000; d[0] = 8'h20;
      wrst_n = 1'b1;
      tick();
      #1;
      total++; if (grant_id !== 2'd0 || busy !== 1'b1 || wdata !== 8'h20) $display("FAIL rmid_restart got id=%0d busy=%0b data=%h exp 0 1 20", grant_id, busy, wdata); else pass++;
      req = '0;
   endtask

`ifdef FIFO_ARB_STATS_EN
   task automatic test_stats();
      do_reset();
      req = 4'b0010; last = 4'b0010; d[1] = 8'h55;
      for (int p = 0; p < 20; p++) begin
         tick();
         tick();
      end
      req = '0; last = '0;
      #1;
      total++; if (stat_pkt_cnt[4 +: 4] !== 4'd15) $display("FAIL stat_saturate got %0d exp 15", stat_pkt_cnt[4 +: 4]); else pass++;
      total++; if (stat_pkt_cnt[0 +: 4] !== 4'd0 || stat_pkt_cnt[8 +: 8] !== 8'd0) $display("FAIL stat_others got %h exp 0 in fields 0,2,3", stat_pkt_cnt); else pass++;
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      #1;
      total++; if (stat_pkt_cnt !== 16'h0 || stat_stall_cnt !== 4'd0) $display("FAIL stat_clr got pkt=%h stall=%0d exp 0 0", stat_pkt_cnt, stat_stall_cnt); else pass++;
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single_packet();
      test_fairness();
      test_stall();
      test_drop_req();
      test_reset_mid_packet();
`ifdef FIFO_ARB_STATS_EN
      test_stats();
`endif
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

endmodule
